// File: rtl/uart_receiver_pkg.sv
// Shared UART definitions: baud encodings, divisor table, receiver states, parity mode.
// The transmitter imports the same package so both halves agree on rates and framing.
package uart_receiver_pkg;

  localparam logic [2:0] BAUD_300    = 3'b000;
  localparam logic [2:0] BAUD_1200   = 3'b001;
  localparam logic [2:0] BAUD_4800   = 3'b010;
  localparam logic [2:0] BAUD_9600   = 3'b011;
  localparam logic [2:0] BAUD_19200  = 3'b100;
  localparam logic [2:0] BAUD_38400  = 3'b101;
  localparam logic [2:0] BAUD_57600  = 3'b110;
  localparam logic [2:0] BAUD_115200 = 3'b111;

  localparam logic PAR_EVEN    = 1'b0;
  localparam logic PAR_ODD     = 1'b1;
  localparam logic PARITY_MODE = PAR_EVEN;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} rx_state_e;

  function automatic int baud_rate(input logic [2:0] sel);
    case (sel)
      BAUD_300:    return 300;
      BAUD_1200:   return 1200;
      BAUD_4800:   return 4800;
      BAUD_9600:   return 9600;
      BAUD_19200:  return 19200;
      BAUD_38400:  return 38400;
      BAUD_57600:  return 57600;
      default:     return 115200;
    endcase
  endfunction

  // Rounded clk/(ovs*baud); at 50 MHz, ovs 16: 10417 .. 27.
  function automatic int baud_div(input int clk_freq, input int ovs, input logic [2:0] sel);
    return (clk_freq + (ovs / 2) * baud_rate(sel)) / (ovs * baud_rate(sel));
  endfunction

endpackage

// File: rtl/uart_receiver_baud_controller.sv
// Oversample tick generator: one-clk sample_ENABLE every DIV clocks for the selected rate.
// Shared with the transmitter, which divides the tick by OVERSAMPLE for its bit clock.
module baud_controller
  import uart_receiver_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  output logic       sample_ENABLE
);

  localparam int CNT_W = $clog2(baud_div(CLK_FREQ, OVERSAMPLE, BAUD_300) + 1);

  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_sel;
  logic [CNT_W-1:0] w_div_m1;

  assign w_div_m1      = CNT_W'(baud_div(CLK_FREQ, OVERSAMPLE, r_sel) - 1);
  assign sample_ENABLE = (r_cnt == w_div_m1);

  // A rate change restarts the count so the first tick at the new rate is a full period.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_sel <= baud_select;
    end else if (baud_select != r_sel) begin
      r_cnt <= '0;
      r_sel <= baud_select;
    end else if (sample_ENABLE) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// UART receive half: 2-flop synchronizer, 16x oversampled deframing of
// start / 8 data LSB-first / even parity / stop, with valid strobe and error flags.
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  input  logic       Rx_EN,
  input  logic       RxD,
  output logic [7:0] Rx_DATA,
  output logic       Rx_VALID,
  output logic       Rx_PERROR,
  output logic       Rx_FERROR
);

  localparam int            TW   = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);

  rx_state_e     r_state;
  logic [1:0]    r_sync;
  logic [TW-1:0] r_tick;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_perr;
  logic          r_armed;
  logic [2:0]    r_baud_q;

  logic w_rxd, w_tick, w_baud_rst, w_baud_chg, w_last;

  assign w_rxd      = r_sync[1];
  assign w_baud_rst = reset | ~Rx_EN;
  assign w_baud_chg = (baud_select != r_baud_q);
  assign w_last     = (r_tick == LAST);

  baud_controller #(.CLK_FREQ(CLK_FREQ), .OVERSAMPLE(OVERSAMPLE)) u_baud (
    .clk           (clk),
    .reset         (w_baud_rst),
    .baud_select   (baud_select),
    .sample_ENABLE (w_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) r_sync <= 2'b11;
    else       r_sync <= {r_sync[0], RxD};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_tick    <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_perr    <= 1'b0;
      r_armed   <= 1'b0;
      r_baud_q  <= baud_select;
      Rx_DATA   <= 8'h00;
      Rx_VALID  <= 1'b0;
      Rx_PERROR <= 1'b0;
      Rx_FERROR <= 1'b0;
    end else begin
      Rx_VALID <= 1'b0;
      r_baud_q <= baud_select;
      // Disabling or changing rate drops any frame; the line must be seen idle before rearming.
      if (!Rx_EN || w_baud_chg) begin
        r_state <= S_IDLE;
        r_armed <= 1'b0;
      end else begin
        if (w_tick && r_state != S_IDLE) r_tick <= w_last ? '0 : r_tick + 1'b1;
        case (r_state)
          S_IDLE: begin
            if (w_rxd) r_armed <= 1'b1;
            else if (r_armed) begin
              r_tick  <= '0;
              r_state <= S_START;
            end
          end
          S_START: begin
            if (w_tick && r_tick == MID) begin
              r_tick <= '0;
              if (w_rxd) r_state <= S_IDLE;
              else begin
                Rx_PERROR <= 1'b0;
                Rx_FERROR <= 1'b0;
                r_bit     <= '0;
                r_perr    <= 1'b0;
                r_state   <= S_DATA;
              end
            end
          end
          S_DATA: begin
            if (w_tick && w_last) begin
              r_shift <= {w_rxd, r_shift[7:1]};
              r_bit   <= r_bit + 1'b1;
              if (r_bit == 3'd7) r_state <= S_PARITY;
            end
          end
          S_PARITY: begin
            if (w_tick && w_last) begin
              r_perr  <= (^{w_rxd, r_shift}) ^ PARITY_MODE;
              r_state <= S_STOP;
            end
          end
          S_STOP: begin
            // A low stop bit (break) leaves the receiver disarmed until the line goes high.
            if (w_tick && w_last) begin
              Rx_PERROR <= r_perr;
              Rx_FERROR <= ~w_rxd;
              if (!r_perr && w_rxd) begin
                Rx_DATA  <= r_shift;
                Rx_VALID <= 1'b1;
              end
              r_armed <= w_rxd;
              r_state <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
